// File: rtl/lcd_video_pkg.sv
// Shared timing defaults, LCD placement helpers and the LCD coordinate record
// used by the LCD video timing generator.
package lcd_video_pkg;

  localparam int WIDTH_DEF        = 360;
  localparam int HEIGHT_DEF       = 360;
  localparam int HBLANK_DEF       = 84;
  localparam int VBLANK_DEF       = 132;
  localparam int HSYNC_OFFSET_DEF = 5;
  localparam int VSYNC_OFFSET_DEF = 5;
  localparam int LCD_COLS_DEF     = 32;
  localparam int LCD_ROWS_DEF     = 16;
  localparam int LCD_PIXEL_DEF    = 11;
  localparam int FETCH_AHEAD_DEF  = 1;
  localparam int H_TOTAL_DEF      = WIDTH_DEF + HBLANK_DEF;
  localparam int V_TOTAL_DEF      = HEIGHT_DEF + VBLANK_DEF;

  // Raster positions, LCD cell indices and sub-pixel offsets
  localparam int POS_W = 10;
  localparam int CRD_W = 10;
  localparam int SUB_W = 5;

  typedef struct packed {
    logic             active;
    logic [CRD_W-1:0] col;
    logic [CRD_W-1:0] row;
    logic [SUB_W-1:0] sub_x;
    logic [SUB_W-1:0] sub_y;
  } lcd_coord_t;

  // The LCD rectangle is centred in the active area
  function automatic int lcd_x_offset(int width, int cols, int pix);
    return (width - cols * pix) / 2;
  endfunction

  function automatic int lcd_y_offset(int height, int rows, int pix);
    return (height - rows * pix) / 2;
  endfunction

  // LCD state matching the fetch position (fa, 0) that reset preloads
  function automatic lcd_coord_t lcd_reset_coord(int fa, int x_off, int y_off,
                                                 int cols, int pix);
    lcd_coord_t c;
    int dx;
    c  = '0;
    dx = fa - x_off;
    if ((dx >= 0) && (dx < cols * pix)) begin
      c.col    = CRD_W'(dx / pix);
      c.sub_x  = SUB_W'(dx % pix);
      c.active = (y_off == 0);
    end
    return c;
  endfunction

endpackage

// File: rtl/lcd_video_timing_if.sv
// Display-side bundle of the LCD video timing generator: raster position,
// sync/DE, LCD grid coordinates and the frame-buffer swap handshake.
interface lcd_video_timing_if import lcd_video_pkg::*; #(
  parameter int LCD_COLS = LCD_COLS_DEF,
  parameter int LCD_ROWS = LCD_ROWS_DEF
);
  localparam int COL_W = $clog2(LCD_COLS);
  localparam int ROW_W = $clog2(LCD_ROWS);

  logic             swap_req;
  logic [POS_W-1:0] x;
  logic [POS_W-1:0] y;
  logic [POS_W-1:0] fetch_x;
  logic [POS_W-1:0] fetch_y;
  logic             de;
  logic             hsync;
  logic             vsync;
  logic             lcd_active;
  logic [COL_W-1:0] lcd_col;
  logic [ROW_W-1:0] lcd_row;
  logic [SUB_W-1:0] lcd_subpixel_x;
  logic [SUB_W-1:0] lcd_subpixel_y;
  logic             swap_ack;
  logic             buffer_sel;
  logic [15:0]      frame_count;

  modport master (
    input  swap_req,
    output x, y, fetch_x, fetch_y, de, hsync, vsync, lcd_active, lcd_col,
           lcd_row, lcd_subpixel_x, lcd_subpixel_y, swap_ack, buffer_sel,
           frame_count
  );

  modport slave (
    output swap_req,
    input  x, y, fetch_x, fetch_y, de, hsync, vsync, lcd_active, lcd_col,
           lcd_row, lcd_subpixel_x, lcd_subpixel_y, swap_ack, buffer_sel,
           frame_count
  );
endinterface

// File: rtl/lcd_video_timing_raster_counter.sv
// Raster-order x/y wrap counter with a reset preload. Exposes its next state
// so the owner can register derived signals aligned with the counter.
module raster_counter import lcd_video_pkg::*; #(
  parameter int H_TOTAL = H_TOTAL_DEF,
  parameter int V_TOTAL = V_TOTAL_DEF,
  parameter int X_INIT  = 0,
  parameter int Y_INIT  = 0
) (
  input  logic             clk,
  input  logic             rst_n_i,
  output logic [POS_W-1:0] x_o,
  output logic [POS_W-1:0] y_o,
  output logic [POS_W-1:0] x_d_o,
  output logic [POS_W-1:0] y_d_o,
  output logic             line_end_o
);
  localparam logic [POS_W-1:0] X_LAST = POS_W'(H_TOTAL - 1);
  localparam logic [POS_W-1:0] Y_LAST = POS_W'(V_TOTAL - 1);
  localparam logic [POS_W-1:0] X_RST  = POS_W'(X_INIT);
  localparam logic [POS_W-1:0] Y_RST  = POS_W'(Y_INIT);

  logic [POS_W-1:0] x_q, y_q, x_d, y_d;
  logic             line_end;

  // Advance one pixel; wrap x at line end and y at frame end
  always_comb begin
    line_end = (x_q == X_LAST);
    x_d      = x_q + 1'b1;
    y_d      = y_q;
    if (line_end) begin
      x_d = '0;
      y_d = (y_q == Y_LAST) ? '0 : y_q + 1'b1;
    end
  end

  // Position register
  always_ff @(posedge clk or negedge rst_n_i) begin
    if (!rst_n_i) begin
      x_q <= X_RST;
      y_q <= Y_RST;
    end else begin
      x_q <= x_d;
      y_q <= y_d;
    end
  end

  assign x_o        = x_q;
  assign y_o        = y_q;
  assign x_d_o      = x_d;
  assign y_d_o      = y_d;
  assign line_end_o = line_end;

endmodule

// File: rtl/lcd_video_timing.sv
// LCD video raster timing: display position with sync/DE, a look-ahead fetch
// position with incrementally tracked LCD grid coordinates, a vblank-aligned
// frame-buffer swap handshake and a frame counter.
module lcd_video_timing import lcd_video_pkg::*; #(
  parameter int WIDTH          = WIDTH_DEF,
  parameter int HEIGHT         = HEIGHT_DEF,
  parameter int HBLANK_LEN     = HBLANK_DEF,
  parameter int VBLANK_LEN     = VBLANK_DEF,
  parameter int HSYNC_OFFSET   = HSYNC_OFFSET_DEF,
  parameter int VSYNC_OFFSET   = VSYNC_OFFSET_DEF,
  parameter int LCD_COLS       = LCD_COLS_DEF,
  parameter int LCD_ROWS       = LCD_ROWS_DEF,
  parameter int LCD_PIXEL_SIZE = LCD_PIXEL_DEF,
  parameter int FETCH_AHEAD    = FETCH_AHEAD_DEF
) (
  input  logic                    clk,
  input  logic                    reset_n,
  lcd_video_timing_if.master      vif
);
  localparam int H_TOTAL      = WIDTH + HBLANK_LEN;
  localparam int V_TOTAL      = HEIGHT + VBLANK_LEN;
  localparam int LCD_W        = LCD_COLS * LCD_PIXEL_SIZE;
  localparam int LCD_H        = LCD_ROWS * LCD_PIXEL_SIZE;
  localparam int LCD_X_OFFSET = lcd_x_offset(WIDTH, LCD_COLS, LCD_PIXEL_SIZE);
  localparam int LCD_Y_OFFSET = lcd_y_offset(HEIGHT, LCD_ROWS, LCD_PIXEL_SIZE);
  localparam int COL_W        = $clog2(LCD_COLS);
  localparam int ROW_W        = $clog2(LCD_ROWS);

  localparam logic [POS_W-1:0] WID_V   = POS_W'(WIDTH);
  localparam logic [POS_W-1:0] HGT_V   = POS_W'(HEIGHT);
  localparam logic [POS_W-1:0] HS_X    = POS_W'(WIDTH + HSYNC_OFFSET);
  localparam logic [POS_W-1:0] VS_Y    = POS_W'(HEIGHT + VSYNC_OFFSET);
  localparam logic [POS_W-1:0] Y_LAST  = POS_W'(V_TOTAL - 1);
  localparam logic [POS_W-1:0] XB      = POS_W'(LCD_X_OFFSET);
  localparam logic [POS_W-1:0] XE      = POS_W'(LCD_X_OFFSET + LCD_W);
  localparam logic [POS_W-1:0] YB      = POS_W'(LCD_Y_OFFSET);
  localparam logic [POS_W-1:0] YE      = POS_W'(LCD_Y_OFFSET + LCD_H);
  localparam logic [SUB_W-1:0] PS_LAST = SUB_W'(LCD_PIXEL_SIZE - 1);
  localparam lcd_coord_t       LCD_RST = lcd_reset_coord(FETCH_AHEAD, LCD_X_OFFSET,
                                                         LCD_Y_OFFSET, LCD_COLS,
                                                         LCD_PIXEL_SIZE);

  // Difference is tested directly: integer halving would round -1 up to 0
  if ((WIDTH < LCD_W) || (HEIGHT < LCD_H)) begin : g_bad_lcd_fit
    $error("lcd_video_timing: LCD rectangle does not fit in the active area");
  end
  if ((FETCH_AHEAD < 1) || (FETCH_AHEAD > 4)) begin : g_bad_fetch_ahead
    $error("lcd_video_timing: FETCH_AHEAD must be within 1..4");
  end

  logic [POS_W-1:0] disp_x, disp_y, disp_x_d, disp_y_d;
  logic [POS_W-1:0] fetch_x, fetch_y, fetch_x_d, fetch_y_d;
  logic             disp_line_end, fetch_line_end, fetch_frame_end;
  logic             vblank_entry;
  logic             fx_in_q, fx_in_d, fy_in_q, fy_in_d;

  logic             de_q, de_d, hsync_q, hsync_d, vsync_q, vsync_d;
  logic             swap_ack_q, swap_ack_d, buffer_sel_q, buffer_sel_d;
  logic [15:0]      frame_count_q, frame_count_d;
  lcd_coord_t       lcd_q, lcd_d;

  raster_counter #(.H_TOTAL(H_TOTAL), .V_TOTAL(V_TOTAL), .X_INIT(0), .Y_INIT(0)) u_disp (
    .clk(clk), .rst_n_i(reset_n), .x_o(disp_x), .y_o(disp_y),
    .x_d_o(disp_x_d), .y_d_o(disp_y_d), .line_end_o(disp_line_end)
  );

  // Runs FETCH_AHEAD pixels ahead in raster order so memory reads can be issued early
  raster_counter #(.H_TOTAL(H_TOTAL), .V_TOTAL(V_TOTAL), .X_INIT(FETCH_AHEAD), .Y_INIT(0)) u_fetch (
    .clk(clk), .rst_n_i(reset_n), .x_o(fetch_x), .y_o(fetch_y),
    .x_d_o(fetch_x_d), .y_d_o(fetch_y_d), .line_end_o(fetch_line_end)
  );

  assign fetch_frame_end = fetch_line_end && (fetch_y == Y_LAST);
  assign vblank_entry    = (disp_x == '0) && (disp_y == HGT_V);
  assign fx_in_q         = (fetch_x >= XB) && (fetch_x < XE);
  assign fy_in_q         = (fetch_y >= YB) && (fetch_y < YE);
  assign fx_in_d         = (fetch_x_d >= XB) && (fetch_x_d < XE);
  assign fy_in_d         = (fetch_y_d >= YB) && (fetch_y_d < YE);

  // Sync/DE from the next display position so they line up with x/y; swap only on vblank entry
  always_comb begin
    de_d          = (disp_x_d < WID_V) && (disp_y_d < HGT_V);
    hsync_d       = (disp_x_d == HS_X);
    vsync_d       = (disp_x_d == '0) && (disp_y_d == VS_Y);
    swap_ack_d    = vblank_entry && vif.swap_req;
    buffer_sel_d  = buffer_sel_q ^ swap_ack_d;
    frame_count_d = frame_count_q;
    if (disp_line_end && (disp_y == Y_LAST)) begin
      frame_count_d = frame_count_q + 16'd1;
    end
  end

  // LCD grid tracking by counting sub-pixels, so no division by the LCD pixel size is needed
  always_comb begin
    lcd_d        = lcd_q;
    lcd_d.active = fx_in_d && fy_in_d;
    if (fx_in_d && fx_in_q) begin
      if (lcd_q.sub_x == PS_LAST) begin
        lcd_d.sub_x = '0;
        lcd_d.col   = lcd_q.col + 1'b1;
      end else begin
        lcd_d.sub_x = lcd_q.sub_x + 1'b1;
      end
    end else begin
      lcd_d.sub_x = '0;
      lcd_d.col   = '0;
    end
    if (fetch_frame_end) begin
      lcd_d.sub_y = '0;
      lcd_d.row   = '0;
    end else if (fetch_line_end) begin
      if (fy_in_d && fy_in_q) begin
        if (lcd_q.sub_y == PS_LAST) begin
          lcd_d.sub_y = '0;
          lcd_d.row   = lcd_q.row + 1'b1;
        end else begin
          lcd_d.sub_y = lcd_q.sub_y + 1'b1;
        end
      end else begin
        lcd_d.sub_y = '0;
        lcd_d.row   = '0;
      end
    end
  end

  // Output registers; reset values match the preloaded positions
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      de_q          <= 1'b1;
      hsync_q       <= 1'b0;
      vsync_q       <= 1'b0;
      swap_ack_q    <= 1'b0;
      buffer_sel_q  <= 1'b0;
      frame_count_q <= '0;
      lcd_q         <= LCD_RST;
    end else begin
      de_q          <= de_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      swap_ack_q    <= swap_ack_d;
      buffer_sel_q  <= buffer_sel_d;
      frame_count_q <= frame_count_d;
      lcd_q         <= lcd_d;
    end
  end

  assign vif.x              = disp_x;
  assign vif.y              = disp_y;
  assign vif.fetch_x        = fetch_x;
  assign vif.fetch_y        = fetch_y;
  assign vif.de             = de_q;
  assign vif.hsync          = hsync_q;
  assign vif.vsync          = vsync_q;
  assign vif.lcd_active     = lcd_q.active;
  assign vif.lcd_col        = COL_W'(lcd_q.col);
  assign vif.lcd_row        = ROW_W'(lcd_q.row);
  assign vif.lcd_subpixel_x = lcd_q.sub_x;
  assign vif.lcd_subpixel_y = lcd_q.sub_y;
  assign vif.swap_ack       = swap_ack_q;
  assign vif.buffer_sel     = buffer_sel_q;
  assign vif.frame_count    = frame_count_q;

endmodule

// File: tb/tb_lcd_video_timing.sv
// Scoreboard bench for lcd_video_timing. A reduced raster keeps frames short;
// two instances (fetch lead 1 and 4) share the swap request.
module tb_lcd_video_timing;
  localparam int W = 40, H = 30, HB = 12, VB = 10, HSO = 5, VSO = 5;
  localparam int COLS = 8, ROWS = 4, PS = 3;
  localparam int HT = W + HB, VT = H + VB, TOT = HT * VT;
  localparam int XOFF = (W - COLS * PS) / 2;
  localparam int YOFF = (H - ROWS * PS) / 2;

  typedef struct {
    bit act;
    int fx, fy, col, row, sx, sy;
  } fexp_t;

  typedef struct {
    int x, y, fc;
    bit de, hs, vs, ack, bsel;
    fexp_t f1, f4;
  } exp_t;

  logic   clk;
  logic   reset_n  = 1'b0;
  logic   swap_req = 1'b0;
  exp_t   sb_q[$];
  int     n_checks = 0;
  int     n_errors = 0;
  longint m_t = 0;
  bit     m_ack = 1'b0;
  bit     m_buf = 1'b0;

  lcd_video_timing_if #(.LCD_COLS(COLS), .LCD_ROWS(ROWS)) vif1 ();
  lcd_video_timing_if #(.LCD_COLS(COLS), .LCD_ROWS(ROWS)) vif4 ();
  assign vif1.swap_req = swap_req;
  assign vif4.swap_req = swap_req;

  lcd_video_timing #(
    .WIDTH(W), .HEIGHT(H), .HBLANK_LEN(HB), .VBLANK_LEN(VB),
    .HSYNC_OFFSET(HSO), .VSYNC_OFFSET(VSO), .LCD_COLS(COLS), .LCD_ROWS(ROWS),
    .LCD_PIXEL_SIZE(PS), .FETCH_AHEAD(1)
  ) u_dut1 (.clk(clk), .reset_n(reset_n), .vif(vif1.master));

  lcd_video_timing #(
    .WIDTH(W), .HEIGHT(H), .HBLANK_LEN(HB), .VBLANK_LEN(VB),
    .HSYNC_OFFSET(HSO), .VSYNC_OFFSET(VSO), .LCD_COLS(COLS), .LCD_ROWS(ROWS),
    .LCD_PIXEL_SIZE(PS), .FETCH_AHEAD(4)
  ) u_dut4 (.clk(clk), .reset_n(reset_n), .vif(vif4.master));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference: everything follows from the cycle count since reset
  function automatic fexp_t fetch_model(longint t, int fa);
    fexp_t f;
    int p, dx, dy;
    p    = (int'(t % TOT) + fa) % TOT;
    f.fx = p % HT;
    f.fy = p / HT;
    dx   = f.fx - XOFF;
    dy   = f.fy - YOFF;
    f.act = (dx >= 0) && (dx < COLS * PS) && (dy >= 0) && (dy < ROWS * PS);
    f.col = f.act ? dx / PS : 0;
    f.sx  = f.act ? dx % PS : 0;
    f.row = f.act ? dy / PS : 0;
    f.sy  = f.act ? dy % PS : 0;
    return f;
  endfunction

  function automatic exp_t full_model(longint t, bit ack, bit bsel);
    exp_t e;
    int p;
    p      = int'(t % TOT);
    e.x    = p % HT;
    e.y    = p / HT;
    e.fc   = int'((t / TOT) % 65536);
    e.de   = (e.x < W) && (e.y < H);
    e.hs   = (e.x == W + HSO);
    e.vs   = (e.x == 0) && (e.y == H + VSO);
    e.ack  = ack;
    e.bsel = bsel;
    e.f1   = fetch_model(t, 1);
    e.f4   = fetch_model(t, 4);
    return e;
  endfunction

  function automatic int cur_x();
    return int'(m_t % TOT) % HT;
  endfunction

  function automatic int cur_y();
    return int'(m_t % TOT) / HT;
  endfunction

  task automatic chk(string name, int act, int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d, time %0t)", name, act, exp, m_t, $time);
    end
  endtask

  task automatic cmp_fetch(string tag, fexp_t f, int fx, int fy, int act,
                           int col, int row, int sx, int sy);
    chk({tag, "fetch_x"}, fx, f.fx);
    chk({tag, "fetch_y"}, fy, f.fy);
    chk({tag, "lcd_active"}, act, int'(f.act));
    if (f.act) begin
      chk({tag, "lcd_col"}, col, f.col);
      chk({tag, "lcd_row"}, row, f.row);
      chk({tag, "lcd_sub_x"}, sx, f.sx);
      chk({tag, "lcd_sub_y"}, sy, f.sy);
    end
  endtask

  // Model: advance on every edge, push the expected post-edge outputs
  initial begin
    int px, py;
    forever begin
      @(posedge clk);
      if (!reset_n) begin
        m_t   = 0;
        m_ack = 1'b0;
        m_buf = 1'b0;
      end else begin
        px    = cur_x();
        py    = cur_y();
        m_ack = (px == 0) && (py == H) && (swap_req == 1'b1);
        if (m_ack) m_buf = !m_buf;
        m_t++;
      end
      sb_q.push_back(full_model(m_t, m_ack, m_buf));
    end
  end

  // Monitor: one expected entry per clock, compared mid-cycle
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL scoreboard_empty: got 0 entries expected 1 (time %0t)", $time);
      end else begin
        e = sb_q.pop_front();
        chk("x", int'(vif1.x), e.x);
        chk("y", int'(vif1.y), e.y);
        chk("de", int'(vif1.de), int'(e.de));
        chk("hsync", int'(vif1.hsync), int'(e.hs));
        chk("vsync", int'(vif1.vsync), int'(e.vs));
        chk("swap_ack", int'(vif1.swap_ack), int'(e.ack));
        chk("buffer_sel", int'(vif1.buffer_sel), int'(e.bsel));
        chk("frame_count", int'(vif1.frame_count), e.fc);
        chk("fa4_x", int'(vif4.x), e.x);
        chk("fa4_y", int'(vif4.y), e.y);
        cmp_fetch("fa1_", e.f1, int'(vif1.fetch_x), int'(vif1.fetch_y),
                  int'(vif1.lcd_active), int'(vif1.lcd_col), int'(vif1.lcd_row),
                  int'(vif1.lcd_subpixel_x), int'(vif1.lcd_subpixel_y));
        cmp_fetch("fa4_", e.f4, int'(vif4.fetch_x), int'(vif4.fetch_y),
                  int'(vif4.lcd_active), int'(vif4.lcd_col), int'(vif4.lcd_row),
                  int'(vif4.lcd_subpixel_x), int'(vif4.lcd_subpixel_y));
      end
    end
  end

  // Inputs change just after the monitor has sampled
  task automatic step(bit polite);
    @(negedge clk);
    #2;
    if (polite && (vif1.swap_ack === 1'b1)) swap_req = 1'b0;
  endtask

  task automatic wait_pos(int tx, int ty, bit polite);
    int budget;
    budget = TOT + 10;
    while (!((cur_x() == tx) && (cur_y() == ty)) && (budget > 0)) begin
      step(polite);
      budget--;
    end
    if (budget == 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL wait_pos: got (%0d,%0d) expected (%0d,%0d)", cur_x(), cur_y(), tx, ty);
    end
  endtask

  initial begin
    repeat (3) step(1'b0);
    reset_n = 1'b1;

    // Request held from mid-frame, dropped after the acknowledge
    wait_pos(10, 5, 1'b0);
    swap_req = 1'b1;
    wait_pos(0, H + 2, 1'b1);
    chk("bufsel_after_first_swap", int'(vif1.buffer_sel), 1);
    chk("req_dropped_after_ack", int'(swap_req), 0);
    step(1'b1);
    wait_pos(0, H + 2, 1'b1);
    chk("bufsel_no_second_swap", int'(vif1.buffer_sel), 1);

    // Request raised mid-vblank waits for the next vblank entry
    wait_pos(0, H + 5, 1'b1);
    swap_req = 1'b1;
    wait_pos(0, H - 1, 1'b1);
    chk("bufsel_waits_next_vblank", int'(vif1.buffer_sel), 1);
    wait_pos(0, H + 2, 1'b1);
    chk("bufsel_after_vblank_swap", int'(vif1.buffer_sel), 0);

    // Request held across two frames swaps once per frame
    swap_req = 1'b1;
    repeat (2 * TOT) step(1'b0);
    swap_req = 1'b0;

    // Random requester behaviour
    for (int i = 0; i < 3 * TOT; i++) begin
      step(1'b1);
      if ($urandom_range(0, 199) == 0) swap_req = !swap_req;
    end

    // Reset mid-frame with a pending request
    swap_req = 1'b0;
    wait_pos(10, 20, 1'b0);
    swap_req = 1'b1;
    wait_pos(20, 25, 1'b0);
    reset_n = 1'b0;
    #1;
    chk("async_rst_x", int'(vif1.x), 0);
    chk("async_rst_y", int'(vif1.y), 0);
    chk("async_rst_fetch_x_fa1", int'(vif1.fetch_x), 1);
    chk("async_rst_fetch_x_fa4", int'(vif4.fetch_x), 4);
    chk("async_rst_fetch_y", int'(vif1.fetch_y), 0);
    chk("async_rst_swap_ack", int'(vif1.swap_ack), 0);
    chk("async_rst_buffer_sel", int'(vif1.buffer_sel), 0);
    chk("async_rst_frame_count", int'(vif1.frame_count), 0);
    chk("async_rst_hsync", int'(vif1.hsync), 0);
    chk("async_rst_vsync", int'(vif1.vsync), 0);
    repeat (2) step(1'b0);
    swap_req = 1'b0;
    reset_n  = 1'b1;

    for (int i = 0; i < TOT + 100; i++) begin
      step(1'b1);
      if ($urandom_range(0, 99) == 0) swap_req = !swap_req;
    end
    step(1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/lcd_video_timing.md
Name: lcd_video_timing

Overview:
- Parametrised raster timing generator for the LCD video path.
- Produces display position, sync and DE for the display. Produces a look-ahead fetch position so the background, sprite and LCD memories can have their registered-read latency hidden.
- Produces LCD grid coordinates (column, row, subpixel) derived incrementally, with no dividers.
- Adds a vblank-aligned frame-buffer swap handshake and a frame counter.

Parameters:
- WIDTH, 360, active pixels per line
- HEIGHT, 360, active lines per frame
- HBLANK_LEN, 84, blank pixels per line; H_TOTAL = WIDTH+HBLANK_LEN
- VBLANK_LEN, 132, blank lines per frame; V_TOTAL = HEIGHT+VBLANK_LEN
- HSYNC_OFFSET, 5, pixels after WIDTH at which hsync pulses
- VSYNC_OFFSET, 5, lines after HEIGHT at which vsync pulses
- LCD_COLS, 32, LCD grid columns
- LCD_ROWS, 16, LCD grid rows
- LCD_PIXEL_SIZE, 11, screen pixels per LCD pixel edge
- FETCH_AHEAD, 1, cycles the fetch position leads the display position; legal range 1..4

Ports:
- clk  in  1  pixel clock
- reset_n  in  1  asynchronous active-low reset
- swap_req  in  1  level request to swap frame buffers; held until swap_ack
- x  out  10  display x, 0..H_TOTAL-1
- y  out  10  display y, 0..V_TOTAL-1
- fetch_x  out  10  x position FETCH_AHEAD pixels ahead (raster order, with wrap)
- fetch_y  out  10  y of fetch position
- de  out  1  x<WIDTH and y<HEIGHT
- hsync  out  1  one-cycle pulse at x==WIDTH+HSYNC_OFFSET
- vsync  out  1  one-cycle pulse at x==0, y==HEIGHT+VSYNC_OFFSET
- lcd_active  out  1  fetch position lies inside the LCD rectangle
- lcd_col  out  $clog2(LCD_COLS)  LCD column at the fetch position
- lcd_row  out  $clog2(LCD_ROWS)  LCD row at the fetch position
- lcd_subpixel_x  out  5  offset within the LCD pixel, 0..LCD_PIXEL_SIZE-1
- lcd_subpixel_y  out  5  offset within the LCD pixel, 0..LCD_PIXEL_SIZE-1
- swap_ack  out  1  one-cycle acknowledge of a swap
- buffer_sel  out  1  currently displayed buffer
- frame_count  out  16  completed frames, wraps at 65535->0

Behaviour:
- Derived constants:
  - LCD_X_OFFSET = (WIDTH - LCD_COLS*LCD_PIXEL_SIZE)/2
  - LCD_Y_OFFSET = (HEIGHT - LCD_ROWS*LCD_PIXEL_SIZE)/2
- Elaboration-time check: fail if either offset is negative, or if FETCH_AHEAD is outside 1..4.
- All outputs are registered and update on the rising clk edge.
- Reset (asynchronous assert, synchronous release):
  - x=0, y=0, fetch_x=FETCH_AHEAD, fetch_y=0
  - hsync=0, vsync=0, swap_ack=0, buffer_sel=0, frame_count=0
  - LCD outputs reflect fetch position (FETCH_AHEAD,0): lcd_active=0 for default parameters.
- Display counter:
  - x increments every cycle.
  - When x==H_TOTAL-1: x->0 and y increments.
  - When y==V_TOTAL-1 at line end: y->0 and frame_count increments.
- Fetch counter: an independent counter with identical wrap rules, initialised FETCH_AHEAD ahead. Invariant every cycle: fetch position == display position + FETCH_AHEAD in raster order, mod H_TOTAL*V_TOTAL.
- de, hsync and vsync are registered so that they align with the x,y values of the same cycle.
- LCD tracking (aligned to fetch_x/fetch_y of the same cycle):
  - lcd_active=1 iff LCD_X_OFFSET <= fetch_x < LCD_X_OFFSET+LCD_COLS*LCD_PIXEL_SIZE, and the same condition holds in y.
  - Horizontal: subpixel_x increments while active and wraps at LCD_PIXEL_SIZE-1; on that wrap lcd_col increments.
  - Horizontal reset: col and subpixel_x return to 0 when fetch_x leaves the rectangle.
  - Vertical: subpixel_y and row advance at each fetch line end, but only within the rectangle rows; both reset to 0 at the fetch frame wrap.
  - Outside the rectangle, col, row and subpixel values are don't-care but must stay stable. The bench checks them only when lcd_active=1.
- Swap handshake:
  - Evaluated on the single vblank-entry cycle, i.e. the display cycle where x wraps to 0 and y becomes HEIGHT.
  - If swap_req=1 on that cycle: swap_ack=1 for exactly the next cycle and buffer_sel toggles simultaneously.
  - swap_req rising mid-vblank or mid-frame waits for the next vblank entry.
  - swap_req still high during the ack cycle does not cause a second swap in the same frame.
  - Requester must drop swap_req after swap_ack; a held request swaps once per frame.
- Reset mid-frame: all state returns immediately to reset values; no partial swap.

Decomposition:
- Shared package lcd_video_pkg holds:
  - timing defaults, computed H_TOTAL/V_TOTAL
  - LCD offset functions
  - lcd_coord_t struct {active, col, row, sub_x, sub_y}
- One sub-module, raster_counter: parametrised x/y wrap counter with a reset-preload value. Instantiated twice: display (preload 0) and fetch (preload FETCH_AHEAD).

Test Plan (all cases use default parameters; H_TOTAL=444, V_TOTAL=492, LCD_X_OFFSET=4, LCD_Y_OFFSET=92):
1. Release reset -> first edge gives x=1, y=0, fetch_x=2. At (443,0) -> next cycle (0,1); at (443,491) -> (0,0) and frame_count 0->1.
2. Fetch wrap -> at display (443,491), fetch=(0,0); at display (442,10), fetch=(443,10). Repeat with FETCH_AHEAD=4: at display (440,491), fetch=(0,0).
3. Sync/DE -> hsync high only at x=365; vsync high only at (0,365); de=1 at (359,359) and de=0 at (360,0) and at (0,360).
4. LCD grid:
   - fetch (4,92) -> active, col0, row0, sub(0,0)
   - fetch (15,92) -> col1, sub_x 0
   - fetch (355,267) -> col31, row15, sub(10,10)
   - fetch (356,92) and (4,268) -> inactive
5. Swap:
   - swap_req held from (100,50) -> swap_ack a single pulse on the cycle after entry to (0,360); buffer_sel 0->1; no ack the next frame if swap_req is dropped.
   - swap_req raised at (0,400) -> ack only at the next frame's (0,360).
6. Assert reset_n=0 at (200,300) during a pending swap_req -> outputs return to reset values asynchronously; buffer_sel stays 0; counting resumes from the reset values.
